mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_array.sv | 24 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder wait-state memory model.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  // Byte address bits below the word index; any of them set is a misaligned access.
  localparam int ADDR_ALIGN_BITS     = 2;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word storage for mem_responder: synchronous write, registered read.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Read-first port; contents are deliberately never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
    rdata <= mem_reg[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder with WAIT_CYCLES wait states before each array access.
// Optional feature: define MEM_PARITY_EN to store and check an even-parity bit per word.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Mem_RdEn,
  input  logic        Mem_WrEn,
  input  logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] Mem_RdData,
  output logic        Mem_ready,
  output logic        Mem_busy,
  output logic        Mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int WW = 33;
`else
  localparam int WW = 32;
`endif
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << ADDR_ALIGN_BITS;
  localparam logic [3:0]  CNT_LOAD   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_e    state_reg;
  logic [3:0]    cnt_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wdata_reg;
  logic          is_wr_reg;
  logic          err_reg;

  logic          req;
  logic [AW-1:0] in_idx;
  logic          in_err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [WW-1:0] ram_wdata;
  logic [WW-1:0] ram_rdata;
  logic          parity_err;
  logic          good_read;

  assign req    = Mem_RdEn | Mem_WrEn;
  assign in_idx = Mem_Addr[AW+ADDR_ALIGN_BITS-1:ADDR_ALIGN_BITS];
  assign in_err = (Mem_Addr[ADDR_ALIGN_BITS-1:0] != '0)
                | ({1'b0, Mem_Addr} >= ADDR_LIMIT)
                | (Mem_RdEn & Mem_WrEn);

  // Present the incoming index while idle so the registered read is ready even with no wait states.
  assign ram_addr  = (state_reg == IDLE) ? in_idx : idx_reg;
  assign ram_we    = (state_reg == ACCESS) & is_wr_reg & ~err_reg;
  assign good_read = ~is_wr_reg & ~err_reg;

`ifdef MEM_PARITY_EN
  assign ram_wdata  = {even_parity(wdata_reg), wdata_reg};
  assign parity_err = ^ram_rdata;
`else
  assign ram_wdata  = wdata_reg;
  assign parity_err = 1'b0;
`endif

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (WW)
  ) u_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      idx_reg    <= '0;
      wdata_reg  <= 32'd0;
      is_wr_reg  <= 1'b0;
      err_reg    <= 1'b0;
      Mem_RdData <= 32'd0;
      Mem_ready  <= 1'b0;
      Mem_busy   <= 1'b0;
      Mem_err    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          Mem_ready <= 1'b0;
          if (req) begin
            idx_reg   <= in_idx;
            wdata_reg <= Mem_WrData;
            is_wr_reg <= Mem_WrEn;
            err_reg   <= in_err;
            cnt_reg   <= CNT_LOAD;
            Mem_busy  <= 1'b1;
            state_reg <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end else begin
            Mem_busy <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ACCESS;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACCESS: begin
          if (good_read) begin
            Mem_RdData <= ram_rdata[31:0];
          end
          Mem_err   <= err_reg | (good_read & parity_err);
          Mem_ready <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          Mem_ready <= 1'b0;
          Mem_busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array model.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int WC    = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        Mem_RdEn = 1'b0;
  logic        Mem_WrEn = 1'b0;
  logic [31:0] Mem_Addr = 32'd0;
  logic [31:0] Mem_WrData = 32'd0;
  logic [31:0] Mem_RdData;
  logic        Mem_ready;
  logic        Mem_busy;
  logic        Mem_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata = 32'd0;

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .Mem_RdEn   (Mem_RdEn),
    .Mem_WrEn   (Mem_WrEn),
    .Mem_Addr   (Mem_Addr),
    .Mem_WrData (Mem_WrData),
    .Mem_RdData (Mem_RdData),
    .Mem_ready  (Mem_ready),
    .Mem_busy   (Mem_busy),
    .Mem_err    (Mem_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One request through the handshake; extra_err marks an error the model cannot see (planted parity flip).
  task automatic run_req(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic extra_err);
    int  lat;
    int  busy_cnt;
    bit  got;
    logic exp_err;
    int  idx;
    exp_err = (addr % 4 != 0) || (addr >= DEPTH * 4) || (rd && wr);
    idx = int'(addr / 4);
    @(negedge clock);
    Mem_RdEn = rd; Mem_WrEn = wr; Mem_Addr = addr; Mem_WrData = data;
    @(posedge clock); #1;
    Mem_RdEn = 1'b0; Mem_WrEn = 1'b0;
    lat = 0; busy_cnt = 0; got = 0;
    while (!got && lat < 40) begin
      if (Mem_busy) busy_cnt++;
      @(posedge clock); #1;
      lat++;
      if (Mem_ready) got = 1;
    end
    if (Mem_busy) busy_cnt++;
    if (!exp_err) begin
      if (wr) model_mem[idx] = data;
      if (rd) exp_rdata = model_mem[idx];
    end
    $display("txn %s rd=%0d wr=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             name, rd, wr, addr, data, Mem_RdData, Mem_err, lat);
    check({name, "_latency"}, 64'(lat), 64'(WC + 1));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(WC + 2));
    check({name, "_err"}, 64'(Mem_err), 64'(exp_err | extra_err));
    check({name, "_rdata"}, 64'(Mem_RdData), 64'(exp_rdata));
    @(posedge clock); #1;
    check({name, "_ready_pulse"}, 64'(Mem_ready), 64'd0);
    check({name, "_idle_busy"}, 64'(Mem_busy), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    int          sel;
    int          seen;

    repeat (3) @(posedge clock);
    #1;
    check("reset_rdata", 64'(Mem_RdData), 64'd0);
    check("reset_ready", 64'(Mem_ready), 64'd0);
    check("reset_busy", 64'(Mem_busy), 64'd0);
    check("reset_err", 64'(Mem_err), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_req("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    run_req("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    run_req("wr13_misaligned", 1'b0, 1'b1, 32'h13, 32'h11111111, 1'b0);
    run_req("rd10_after_err", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    run_req("wr20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0);
    run_req("rdwr20_both", 1'b1, 1'b1, 32'h20, 32'h22222222, 1'b0);
    run_req("rd20_unchanged", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    run_req("wr_out_of_range", 1'b0, 1'b1, 32'(DEPTH * 4), 32'h33333333, 1'b0);
    run_req("rd_out_of_range", 1'b1, 1'b0, 32'(DEPTH * 4 + 8), 32'h0, 1'b0);
    run_req("rd_last_word", 1'b1, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, 1'b0);
    run_req("wr40", 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 1'b0);

    // Abort a write to 0x40 with reset_n asserted in the middle of the wait states.
    @(negedge clock);
    Mem_WrEn = 1'b1; Mem_Addr = 32'h40; Mem_WrData = 32'h12345678;
    @(posedge clock); #1;
    Mem_WrEn = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy_async", 64'(Mem_busy), 64'd0);
    check("abort_rdata_async", 64'(Mem_RdData), 64'd0);
    exp_rdata = 32'd0;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (Mem_ready || Mem_busy) seen++;
    end
    check("abort_no_ready", 64'(seen), 64'd0);
    run_req("rd40_after_abort", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

`ifdef MEM_PARITY_EN
    dut.u_array.mem_reg[4][32] = ~dut.u_array.mem_reg[4][32];
    run_req("rd10_parity_flip", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    run_req("wr10_restore", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    run_req("rd10_parity_ok", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      run_req("prefill", 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 15)) * 4;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63)) * 4;
      d  = $urandom;
      rd = 1'($urandom_range(0, 1));
      wr = ~rd;
      if (sel == 2) begin
        rd = 1'b1; wr = 1'b1;
      end
      run_req("random", rd, wr, a, d, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
